// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: two read ports, two write ports,
// optional write-to-read bypass and a sequential debug scan engine.
module regfile_mp #(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 16,
    parameter  bit BYPASS = 1'b1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [AW-1:0]    A,
    input  logic [AW-1:0]    B,
    output logic [WIDTH-1:0] PA,
    output logic [WIDTH-1:0] PB,
    input  logic             RF,
    input  logic [AW-1:0]    C,
    input  logic [WIDTH-1:0] PC,
    input  logic             WEn,
    input  logic [AW-1:0]    WAddr,
    input  logic [WIDTH-1:0] WData,
    input  logic             DbgStart,
    output logic             DbgValid,
    output logic [AW-1:0]    DbgIdx,
    output logic [WIDTH-1:0] DbgData,
    output logic             DbgLast,
    output logic             DbgBusy
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [AW-1:0]    dbg_idx_q, dbg_idx_d;
    logic [WIDTH-1:0] dbg_data_q, dbg_data_d;

    // Port C is assigned last so it wins a same-address collision.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (WEn) begin
                mem_q[WAddr] <= WData;
            end
            if (RF) begin
                mem_q[C] <= PC;
            end
        end
    end

    assign PA = (BYPASS && RF && (A == C))      ? PC    :
                (BYPASS && WEn && (A == WAddr)) ? WData : mem_q[A];
    assign PB = (BYPASS && RF && (B == C))      ? PC    :
                (BYPASS && WEn && (B == WAddr)) ? WData : mem_q[B];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            dbg_idx_q  <= '0;
            dbg_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            dbg_idx_q  <= dbg_idx_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        last_d     = last_q;
        dbg_idx_d  = dbg_idx_q;
        dbg_data_d = dbg_data_q;
        unique case (state_q)
            IDLE: begin
                if (DbgStart) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                // The beat after the last capture is the only point a new start is taken.
                if (last_q) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    idx_d   = '0;
                    if (!DbgStart) begin
                        state_d = IDLE;
                    end
                end else begin
                    dbg_data_d = mem_q[idx_q];
                    dbg_idx_d  = idx_q;
                    valid_d    = 1'b1;
                    last_d     = (idx_q == AW'(DEPTH - 1));
                    idx_d      = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign DbgValid = valid_q;
    assign DbgLast  = last_q;
    assign DbgIdx   = dbg_idx_q;
    assign DbgData  = dbg_data_q;
    assign DbgBusy  = (state_q == SCAN);

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default, no-bypass and 16x64 builds
// checked against array models of the register contents.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  a, b, c, wa;
    logic        rf, wen, ds0, ds2;
    logic [31:0] pc, wd;

    logic [31:0] pa0, pb0, pa1, pb1, dd0, dd1;
    logic [15:0] pa2, pb2, dd2;
    logic [3:0]  di0, di1;
    logic [5:0]  di2;
    logic        dv0, dl0, db0, dv1, dl1, db1, dv2, dl2, db2;

    int total = 0;
    int bad   = 0;

    logic [31:0] m16 [16];
    logic [15:0] m64 [64];

    always #5 clk = ~clk;

    regfile_mp u0 (
        .Clk(clk), .Rst_n(rst_n), .A(a[3:0]), .B(b[3:0]), .PA(pa0), .PB(pb0),
        .RF(rf), .C(c[3:0]), .PC(pc), .WEn(wen), .WAddr(wa[3:0]), .WData(wd),
        .DbgStart(ds0), .DbgValid(dv0), .DbgIdx(di0), .DbgData(dd0),
        .DbgLast(dl0), .DbgBusy(db0)
    );

    regfile_mp #(.BYPASS(1'b0)) u1 (
        .Clk(clk), .Rst_n(rst_n), .A(a[3:0]), .B(b[3:0]), .PA(pa1), .PB(pb1),
        .RF(rf), .C(c[3:0]), .PC(pc), .WEn(wen), .WAddr(wa[3:0]), .WData(wd),
        .DbgStart(1'b0), .DbgValid(dv1), .DbgIdx(di1), .DbgData(dd1),
        .DbgLast(dl1), .DbgBusy(db1)
    );

    regfile_mp #(.WIDTH(16), .DEPTH(64)) u2 (
        .Clk(clk), .Rst_n(rst_n), .A(a), .B(b), .PA(pa2), .PB(pb2),
        .RF(rf), .C(c), .PC(pc[15:0]), .WEn(wen), .WAddr(wa), .WData(wd[15:0]),
        .DbgStart(ds2), .DbgValid(dv2), .DbgIdx(di2), .DbgData(dd2),
        .DbgLast(dl2), .DbgBusy(db2)
    );

    function automatic logic [31:0] e16(input logic [3:0] ad, input bit byp);
        if (byp && rf && ad == c[3:0]) return pc;
        if (byp && wen && ad == wa[3:0]) return wd;
        return m16[ad];
    endfunction

    function automatic logic [15:0] e64(input logic [5:0] ad);
        if (rf && ad == c) return pc[15:0];
        if (wen && ad == wa) return wd[15:0];
        return m64[ad];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) m16[i] = '0;
        for (int i = 0; i < 64; i++) m64[i] = '0;
    endtask

    task automatic step();
        @(posedge clk);
        if (wen) begin
            m16[wa[3:0]] = wd;
            m64[wa] = wd[15:0];
        end
        if (rf) begin
            m16[c[3:0]] = pc;
            m64[c] = pc[15:0];
        end
        #1;
    endtask

    task automatic idle_in();
        rf = 0; wen = 0; ds0 = 0; ds2 = 0;
        c = 0; wa = 0; pc = 0; wd = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; a = 0; b = 0;
        idle_in();
        clear_model();
        step(); step();
        total++;
        if (dv0 !== 0 || db0 !== 0 || dl0 !== 0 || di0 !== 0 || dd0 !== 0) begin
            bad++;
            $display("FAIL reset_dbg: v=%b b=%b l=%b i=%0d d=%h need zeros",
                     dv0, db0, dl0, di0, dd0);
        end
        rst_n = 1;
        rf = 1; c = 3; pc = 32'hDEADBEEF;
        step();
        rf = 0; a = 3;
        ds0 = 1; step(); ds0 = 0;
        step(); step();
        #2 rst_n = 0;
        clear_model();
        #1;
        total++;
        if (pa1 !== 32'h0 || pa0 !== 32'h0) begin
            bad++;
            $display("FAIL reset_async_clear: pa0=%h pa1=%h need 0", pa0, pa1);
        end
        total++;
        if (db0 !== 0 || dv0 !== 0 || di0 !== 0 || dd0 !== 0) begin
            bad++;
            $display("FAIL reset_abort: busy=%b v=%b i=%0d d=%h need 0",
                     db0, dv0, di0, dd0);
        end
        #1 rst_n = 1;
        step(); step();
        total++;
        if (dv0 !== 0 || db0 !== 0) begin
            bad++;
            $display("FAIL reset_no_partial: v=%b busy=%b need 0", dv0, db0);
        end
    endtask

    task automatic test_dual_write();
        rf = 1; c = 2; pc = 32'h11;
        wen = 1; wa = 5; wd = 32'h22;
        step();
        idle_in();
        a = 2; b = 5; #1;
        total++;
        if (pa1 !== 32'h11 || pb1 !== 32'h22) begin
            bad++;
            $display("FAIL dual_write: r2=%h r5=%h need 11 22", pa1, pb1);
        end
        rf = 1; c = 2; pc = 32'h11;
        wen = 1; wa = 2; wd = 32'h33;
        step();
        idle_in();
        a = 2; #1;
        total++;
        if (pa1 !== m16[2] || pa1 !== 32'h11) begin
            bad++;
            $display("FAIL dual_same_addr: r2=%h need 11", pa1);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] old7;
        wen = 1; wa = 7; wd = 32'h1234_5678;
        step();
        idle_in();
        old7 = m16[7];
        a = 7; rf = 1; c = 7; pc = 32'hA5A5A5A5;
        wen = 1; wa = 7; wd = 32'h0BAD_0BAD;
        #1;
        total++;
        if (pa0 !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL bypass_same_cycle: pa=%h need a5a5a5a5", pa0);
        end
        total++;
        if (pa1 !== old7) begin
            bad++;
            $display("FAIL nobypass_old: pa=%h need %h", pa1, old7);
        end
        step();
        idle_in();
        #1;
        total++;
        if (pa1 !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL nobypass_after_edge: pa=%h need a5a5a5a5", pa1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            a  = $urandom_range(0, 1) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
            b  = $urandom_range(0, 1) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
            c  = $urandom_range(0, 1) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
            wa = $urandom_range(0, 1) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
            rf  = 1'($urandom_range(0, 1));
            wen = 1'($urandom_range(0, 1));
            pc = $urandom;
            wd = $urandom;
            #1;
            total++;
            if (pa0 !== e16(a[3:0], 1) || pb0 !== e16(b[3:0], 1)) begin
                bad++;
                $display("FAIL rand_byp n=%0d: pa=%h pb=%h need %h %h",
                         n, pa0, pb0, e16(a[3:0], 1), e16(b[3:0], 1));
            end
            total++;
            if (pa1 !== e16(a[3:0], 0) || pb1 !== e16(b[3:0], 0)) begin
                bad++;
                $display("FAIL rand_nobyp n=%0d: pa=%h pb=%h need %h %h",
                         n, pa1, pb1, e16(a[3:0], 0), e16(b[3:0], 0));
            end
            total++;
            if (pa2 !== e64(a) || pb2 !== e64(b)) begin
                bad++;
                $display("FAIL rand_w16 n=%0d: pa=%h pb=%h need %h %h",
                         n, pa2, pb2, e64(a), e64(b));
            end
            step();
        end
        idle_in();
    endtask

    task automatic test_scan();
        logic [31:0] exp;
        for (int i = 0; i < 16; i++) begin
            idle_in();
            if (i % 2 == 0) begin
                rf = 1; c = 6'(i); pc = 32'(i * 32'h101);
            end else begin
                wen = 1; wa = 6'(i); wd = 32'(i * 32'h101);
            end
            step();
        end
        idle_in();
        ds0 = 1; step(); ds0 = 0;
        total++;
        if (db0 !== 1 || dv0 !== 0) begin
            bad++;
            $display("FAIL scan_start: busy=%b v=%b need 1 0", db0, dv0);
        end
        exp = '0;
        for (int k = 0; k < 16; k++) begin
            exp = m16[k];
            if (k == 2) begin rf = 1; c = 9; pc = 32'hFFFF; end
            if (k == 4) begin rf = 1; c = 4; pc = 32'hFFFF; end
            if (k == 6) ds0 = 1;
            step();
            idle_in();
            total++;
            if (dv0 !== 1 || di0 !== 4'(k) || dd0 !== exp || dl0 !== (k == 15)) begin
                bad++;
                $display("FAIL scan_beat k=%0d: v=%b i=%0d d=%h l=%b need 1 %0d %h %b",
                         k, dv0, di0, dd0, dl0, k, exp, k == 15);
            end
        end
        step();
        total++;
        if (dv0 !== 0 || dl0 !== 0 || db0 !== 0 || di0 !== 4'd15 || dd0 !== exp) begin
            bad++;
            $display("FAIL scan_end: v=%b l=%b busy=%b i=%0d d=%h need 0 0 0 15 %h",
                     dv0, dl0, db0, di0, dd0, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        ds0 = 1; step(); ds0 = 0;
        for (int k = 0; k < 16; k++) step();
        total++;
        if (dl0 !== 1 || dv0 !== 1) begin
            bad++;
            $display("FAIL b2b_last: l=%b v=%b need 1 1", dl0, dv0);
        end
        ds0 = 1; step(); ds0 = 0;
        total++;
        if (dv0 !== 0 || db0 !== 1) begin
            bad++;
            $display("FAIL b2b_gap: v=%b busy=%b need 0 1", dv0, db0);
        end
        exp = m16[0];
        step();
        total++;
        if (dv0 !== 1 || di0 !== 4'd0 || dd0 !== exp) begin
            bad++;
            $display("FAIL b2b_restart: v=%b i=%0d d=%h need 1 0 %h", dv0, di0, dd0, exp);
        end
        for (int k = 0; k < 16; k++) step();
        total++;
        if (db0 !== 0 || dv0 !== 0) begin
            bad++;
            $display("FAIL b2b_drain: busy=%b v=%b need 0 0", db0, dv0);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] exp;
        for (int i = 0; i < 64; i++) begin
            rf = 1; c = 6'(i); pc = $urandom;
            step();
        end
        idle_in();
        ds2 = 1; step(); ds2 = 0;
        total++;
        if (db2 !== 1 || dv2 !== 0) begin
            bad++;
            $display("FAIL sweep_start: busy=%b v=%b need 1 0", db2, dv2);
        end
        for (int k = 0; k < 64; k++) begin
            exp = m64[k];
            step();
            total++;
            if (dv2 !== 1 || di2 !== 6'(k) || dd2 !== exp || dl2 !== (k == 63)) begin
                bad++;
                $display("FAIL sweep_beat k=%0d: v=%b i=%0d d=%h l=%b need 1 %0d %h %b",
                         k, dv2, di2, dd2, dl2, k, exp, k == 63);
            end
        end
        step();
        total++;
        if (dv2 !== 0 || db2 !== 0) begin
            bad++;
            $display("FAIL sweep_end: v=%b busy=%b need 0 0", dv2, db2);
        end
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_bypass();
        test_random();
        test_scan();
        test_back_to_back();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
